// File: rtl/ram_pkg.sv
// Shared sizing for the 16x64 dual-port RAM and the FIFO controller that drives it.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ram_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    // Occupancy counters need one extra bit so that DEPTH itself is representable.
    localparam int CNT_W = 5;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output skid buffer holding words returned by the RAM read port.
// Latency: a word written on an edge is visible at head_data in the following cycle.
// Backpressure: none internally; the upstream credit logic never writes while full.
module fifo_out_buf
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [1:0]        cnt,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid
);

    logic [DATA_W-1:0] mem [2];
    logic              head;
    logic              tail;

    // Store at the tail, advance head on pop, and track occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_data;
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head is a mux of registers only, so the consumer never sees a path from the RAM.
    assign head_data  = mem[head];
    assign head_valid = (cnt != 2'd0);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO pointer/credit controller in front of a 16x64 dual-port RAM with write-to-read override.
// Latency: push to out_valid is 2 cycles on an empty queue; sustains one push and one pop per cycle.
// Backpressure: in_ready drops when 16 words sit in RAM; reads stall while the output buffer has no credit.
module ram_fifo_ctrl
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  level,
    output logic              ram_we,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [ADDR_W-1:0] ram_read_addr,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_read_data
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_addr_hold;
    logic [ADDR_W-1:0] rd_addr_hold;
    logic [DATA_W-1:0] wr_data_hold;
    logic [CNT_W-1:0]  ram_cnt;
    logic [CNT_W-1:0]  ram_cnt_nxt;
    logic [CNT_W-1:0]  level_nxt;
    logic              rd_pend;
    logic [1:0]        buf_cnt;
    logic [1:0]        buf_cnt_nxt;
    logic [2:0]        credit;
    logic              push;
    logic              pop;
    logic              issue;

    // Handshakes: in_ready looks only at registered occupancy, never at this cycle's read.
    assign in_ready = (ram_cnt != DEPTH_CNT) && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Words already in the buffer or returning next cycle, less the one leaving now.
    // A pop implies buf_cnt >= 1, so the 3-bit sum cannot underflow.
    assign credit = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop};

    // A same-cycle push counts as RAM content: with rd_ptr == wr_ptr the RAM override
    // hands the incoming word straight back, which is what gives the 2-cycle latency.
    assign issue = ((ram_cnt != '0) || push) && (credit < 3'd2) && !reset;

    // RAM ports are live only while pushing/issuing; otherwise they hold the last values.
    assign ram_we         = push;
    assign ram_re         = issue;
    assign ram_write_addr = push  ? wr_ptr  : wr_addr_hold;
    assign ram_write_data = push  ? in_data : wr_data_hold;
    assign ram_read_addr  = issue ? rd_ptr  : rd_addr_hold;

    // Next-state occupancy for RAM and output buffer, and the total level derived from them.
    always_comb begin
        ram_cnt_nxt = ram_cnt;
        buf_cnt_nxt = buf_cnt;
        case ({push, issue})
            2'b10:   ram_cnt_nxt = ram_cnt + 5'd1;
            2'b01:   ram_cnt_nxt = ram_cnt - 5'd1;
            default: ram_cnt_nxt = ram_cnt;
        endcase
        case ({rd_pend, pop})
            2'b10:   buf_cnt_nxt = buf_cnt + 2'd1;
            2'b01:   buf_cnt_nxt = buf_cnt - 2'd1;
            default: buf_cnt_nxt = buf_cnt;
        endcase
        level_nxt = ram_cnt_nxt + {4'b0000, issue} + {3'b000, buf_cnt_nxt};
    end

    // Pointers, counters, in-flight flag and the held RAM port values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wr_addr_hold <= '0;
            rd_addr_hold <= '0;
            wr_data_hold <= '0;
            ram_cnt      <= '0;
            rd_pend      <= 1'b0;
            level        <= '0;
        end else begin
            if (push) begin
                wr_ptr       <= wr_ptr + 1'b1;
                wr_addr_hold <= wr_ptr;
                wr_data_hold <= in_data;
            end
            if (issue) begin
                rd_ptr       <= rd_ptr + 1'b1;
                rd_addr_hold <= rd_ptr;
            end
            ram_cnt <= ram_cnt_nxt;
            rd_pend <= issue;
            level   <= level_nxt;
        end
    end

    // Output buffer is filled from the RAM one cycle after each issued read; rd_pend is
    // cleared by reset, so a read in flight across reset is dropped.
    fifo_out_buf u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (rd_pend),
        .wr_data    (ram_read_data),
        .pop        (pop),
        .cnt        (buf_cnt),
        .head_data  (out_data),
        .head_valid (out_valid)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural RAM alongside and a queue-based reference.
// Latency: n/a.
// Backpressure: driven randomly and in directed fill/drain scenarios.
module tb_ram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
    logic [4:0]  level;
    logic        ram_we;
    logic        ram_re;
    logic [3:0]  ram_write_addr;
    logic [3:0]  ram_read_addr;
    logic [63:0] ram_write_data;
    logic [63:0] ram_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] model_q[$];
    logic [63:0] ram_mem [16];

    always #5 clk = ~clk;

    ram_fifo_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .level          (level),
        .ram_we         (ram_we),
        .ram_re         (ram_re),
        .ram_write_addr (ram_write_addr),
        .ram_read_addr  (ram_read_addr),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    // Behavioural 16x64 RAM with same-address write-to-read override.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_write_addr] <= ram_write_data;
        if (ram_re) ram_read_data <= (ram_we && ram_write_addr == ram_read_addr) ?
                                     ram_write_data : ram_mem[ram_read_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // One cycle: drive at negedge, record handshakes, update reference queue, return at next negedge.
    task automatic step(input logic iv, input logic [63:0] d, input logic ordy,
                        output logic pushed, output logic popped,
                        output logic [63:0] got, output logic [63:0] want);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        pushed = in_valid && in_ready;
        popped = out_valid && out_ready;
        got    = out_data;
        want   = ~out_data;
        if (popped && model_q.size() > 0) want = model_q.pop_front();
        if (pushed) model_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b want=0", ram_we); end
        n_tests++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL reset_re got=%b want=0", ram_re); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        model_q.delete();
        #1;
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", level); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if (out_data !== 64'd0) begin n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 64'd5; out_ready = 1'b1;
        #1;
        n_tests++; if (ram_we !== 1'b1 || ram_re !== 1'b1) begin n_fail++; $display("FAIL single_we_re got=%b%b want=11", ram_we, ram_re); end
        n_tests++; if (ram_write_addr !== 4'd0 || ram_read_addr !== 4'd0) begin n_fail++; $display("FAIL single_addr got=%0d/%0d want=0/0", ram_write_addr, ram_read_addr); end
        n_tests++; if (ram_write_data !== 64'd5) begin n_fail++; $display("FAIL single_wdata got=%0d want=5", ram_write_data); end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got=%b want=0", out_valid); end
        n_tests++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level_n1 got=%0d want=1", level); end
        n_tests++; if (ram_we !== 1'b0 || ram_write_addr !== 4'd0 || ram_write_data !== 64'd5) begin n_fail++; $display("FAIL single_idle_hold got=%b/%0d/%0d want=0/0/5", ram_we, ram_write_addr, ram_write_data); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (out_valid !== 1'b1 || out_data !== 64'd5) begin n_fail++; $display("FAIL single_out got=%b/%0d want=1/5", out_valid, out_data); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (level !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%0d/%b want=0/0", level, out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic pu, po;
        logic [63:0] g, w;
        int acc = 0;
        int cyc = 0;
        while (acc < 18 && cyc < 100) begin
            step(1'b1, 64'(acc + 1), 1'b0, pu, po, g, w);
            if (pu) acc++;
            cyc++;
            n_tests++; if (level !== 5'(model_q.size())) begin n_fail++; $display("FAIL fill_level got=%0d want=%0d", level, model_q.size()); end
        end
        n_tests++; if (cyc != 18) begin n_fail++; $display("FAIL fill_cycles got=%0d want=18", cyc); end
        n_tests++; if (in_ready !== 1'b0 || level !== 5'd18) begin n_fail++; $display("FAIL fill_full got=%b/%0d want=0/18", in_ready, level); end
        step(1'b1, 64'd99, 1'b0, pu, po, g, w);
        n_tests++; if (pu !== 1'b0 || level !== 5'd18) begin n_fail++; $display("FAIL fill_refuse got=%b/%0d want=0/18", pu, level); end
        // Push attempt and pop together while full: push refused, pop frees credit.
        step(1'b1, 64'd100, 1'b1, pu, po, g, w);
        n_tests++; if (pu !== 1'b0 || po !== 1'b1 || g !== 64'd1) begin n_fail++; $display("FAIL full_pushpop got=%b/%b/%0d want=0/1/1", pu, po, g); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_rise got=%b want=1", in_ready); end
        for (int i = 2; i <= 18; i++) begin
            step(1'b0, 64'd0, 1'b1, pu, po, g, w);
            n_tests++; if (po !== 1'b1 || g !== 64'(i) || g !== w) begin n_fail++; $display("FAIL drain_word got=%b/%0d want=1/%0d", po, g, i); end
        end
        n_tests++; if (level !== 5'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty got=%0d/%b want=0/0", level, out_valid); end
    endtask

    task automatic test_back_to_back();
        logic pu, po;
        logic [63:0] g, w;
        int acc = 0;
        int pops = 0;
        int cyc = 0;
        int stalls = 0;
        while (pops < 40 && cyc < 100) begin
            step(acc < 40, 64'(1000 + acc), 1'b1, pu, po, g, w);
            if (acc < 40 && !pu) stalls++;
            if (pu) acc++;
            if (po) begin
                pops++;
                n_tests++; if (g !== w) begin n_fail++; $display("FAIL stream_order got=%0d want=%0d", g, w); end
            end
            cyc++;
        end
        n_tests++; if (cyc != 42) begin n_fail++; $display("FAIL stream_cycles got=%0d want=42", cyc); end
        n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL stream_stalls got=%0d want=0", stalls); end
        n_tests++; if (model_q.size() != 0 || level !== 5'd0) begin n_fail++; $display("FAIL stream_empty got=%0d want=0", level); end
    endtask

    task automatic test_random();
        logic pu, po;
        logic [63:0] g, w;
        int guard = 0;
        for (int c = 0; c < 2000; c++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), pu, po, g, w);
            if (po) begin
                n_tests++; if (g !== w) begin n_fail++; $display("FAIL rand_data cyc=%0d got=%h want=%h", c, g, w); end
            end
            n_tests++; if (level !== 5'(model_q.size())) begin n_fail++; $display("FAIL rand_level cyc=%0d got=%0d want=%0d", c, level, model_q.size()); end
            n_tests++; if (model_q.size() == 0 && out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_phantom cyc=%0d got=%b want=0", c, out_valid); end
        end
        while (model_q.size() > 0 && guard < 60) begin
            step(1'b0, 64'd0, 1'b1, pu, po, g, w);
            if (po) begin
                n_tests++; if (g !== w) begin n_fail++; $display("FAIL rand_drain got=%h want=%h", g, w); end
            end
            guard++;
        end
        n_tests++; if (model_q.size() != 0 || level !== 5'd0) begin n_fail++; $display("FAIL rand_final got=%0d/%0d want=0/0", model_q.size(), level); end
    endtask

    task automatic test_reset_mid();
        logic pu, po;
        logic [63:0] g, w;
        int cyc = 0;
        int pops = 0;
        while (model_q.size() < 10 && cyc < 60) begin
            step(1'b1, 64'(500 + cyc), 1'b0, pu, po, g, w);
            cyc++;
        end
        // One pop leaves a RAM read in flight across the reset edge.
        step(1'b0, 64'd0, 1'b1, pu, po, g, w);
        n_tests++; if (level !== 5'd9) begin n_fail++; $display("FAIL mid_level_pre got=%0d want=9", level); end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        #1;
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("FAIL mid_level got=%0d want=0", level); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
        cyc = 0;
        while ((cyc < 3 || model_q.size() > 0) && cyc < 30) begin
            step(cyc < 3, 64'hC0 + 64'(cyc), 1'b1, pu, po, g, w);
            if (po) begin
                pops++;
                n_tests++; if (g !== w) begin n_fail++; $display("FAIL mid_data got=%h want=%h", g, w); end
            end
            cyc++;
        end
        n_tests++; if (pops != 3 || level !== 5'd0) begin n_fail++; $display("FAIL mid_pops got=%0d/%0d want=3/0", pops, level); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Pointer and flow-control stage that sits directly upstream of the 16x64 dual-port `ram_overriding` memory and turns it into a first-in/first-out queue. It drives the RAM write port (`we`, `write_addr`, `write_data`) and read port (`re`, `read_addr`), and captures `read_data` into a 2-entry output buffer. Producer and consumer see valid/ready handshakes, and the controller sustains one push and one pop per cycle. It uses the RAM's same-address write-to-read override to cut empty-queue latency.

## Interface
- `DATA_W`, 64, word width; matches the RAM.
- `ADDR_W`, 4, RAM address width.
- `DEPTH`, 16, RAM entries; equals 2**ADDR_W.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  producer has a word.
- `in_data`  in  DATA_W  producer word.
- `in_ready`  out  1  controller accepts; push = in_valid & in_ready.
- `out_valid`  out  1  head word available.
- `out_data`  out  DATA_W  head word.
- `out_ready`  in  1  consumer takes; pop = out_valid & out_ready.
- `level`  out  5  total words held (RAM + in-flight + buffer), 0..18.
- `ram_we`, `ram_re`  out  1 each  to RAM `we` / `re`.
- `ram_write_addr`, `ram_read_addr`  out  ADDR_W each  to RAM addresses.
- `ram_write_data`  out  DATA_W  to RAM `write_data`.
- `ram_read_data`  in  DATA_W  from RAM `read_data`.

## Operation
- RAM contract: on an edge with `re`=1, `read_data` <= mem[`read_addr`]. If `we`=1 and the addresses are equal, `read_data` <= `write_data` instead (override). `read_data` is valid for the whole next cycle.
- State: `wr_ptr`, `rd_ptr` (ADDR_W, wrap 15->0 naturally), `ram_cnt` (0..16, words written but not yet read-issued), `rd_pend` (1 bit, read issued last edge), and output buffer `buf_cnt` (0..2) with head/tail.
- `in_ready` = (`ram_cnt` != DEPTH) & !`reset`. It depends on registered state only, so it is 0 when full even if a read issues that cycle.
- Push: `ram_we`=1, `ram_write_addr`=`wr_ptr`, `ram_write_data`=`in_data`; `wr_ptr`++.
- Read issue: `issue` = (`ram_cnt` != 0 | push) & (`buf_cnt` + `rd_pend` - pop < 2) & !`reset`. Then `ram_re`=1, `ram_read_addr`=`rd_ptr`, and `rd_ptr`++.
- When `ram_cnt`==0 and push, the issue uses `rd_ptr`==`wr_ptr`, so the override returns `in_data`.
- Updates:
  - `ram_cnt` += push - issue.
  - `rd_pend` <= issue.
  - If `rd_pend`, `ram_read_data` is written at the buffer tail.
  - `buf_cnt` += `rd_pend` - pop.
- `out_valid` = `buf_cnt` != 0; `out_data` = buffer head; registered, with no combinational path from `ram_read_data`.
- `level` = `ram_cnt` + `rd_pend` + `buf_cnt`, registered.
- Widths: `ram_cnt` and `level` are 5 bits. The credit sum is computed in 3 bits, so no overflow.
- When idle (no push or issue), `ram_we` and `ram_re` are 0 and the address/data outputs hold their last values.

## Timing
- Reset, effective on the edge with `reset`=1:
  - `wr_ptr`, `rd_ptr`, `ram_cnt`, `rd_pend`, `buf_cnt`, `level` = 0.
  - `out_valid` = 0, buffer data = 0.
  - `ram_we`, `ram_re`, `in_ready` are 0 while `reset` is high.
- Reset mid-operation: all queued words are discarded, and an in-flight `ram_read_data` is ignored. `in_ready`=1 in the first cycle after reset deasserts.
- Push-to-`out_valid` latency on an empty queue: push in cycle N, `out_valid`=1 in cycle N+2.
- Throughput: with `out_ready` held high, one pop per cycle indefinitely.
- Full: `ram_cnt`==16 gives `in_ready`=0. Total capacity is 18 words with the buffer full.
- Simultaneous push and pop while full: the pop frees buffer credit, so a read issues and `in_ready` rises the next cycle.
- Pop with `buf_cnt`==0 cannot occur (`out_valid`=0).
- Backpressure: with `out_ready`=0 and `buf_cnt`+`rd_pend`=2, no reads issue; the RAM holds the words.

## Structure
- Shared package `ram_pkg` holds `DATA_W`, `ADDR_W`, and `DEPTH`; the RAM and this block both import it.
- Sub-module `fifo_out_buf` is the 2-entry output buffer.
  - Inputs: `wr_en`, `wr_data`, `pop`.
  - Outputs: `cnt`, `head_data`, `head_valid`.
- The top level holds the pointers, counters, and issue/credit logic.
- The RAM is instantiated beside this block by the parent, not inside it.

## Test plan
- Reset, then push 64'd5 with `out_ready`=1 on an empty queue → `ram_we` and `ram_re` both 1 at addr 0 in the same cycle; `out_valid`=1 with `out_data`=5 two cycles later; `level` returns to 0.
- Push 1..18 with `out_ready`=0 → `in_ready` drops after word 16 is in RAM; `level`=18 at steady state. Then pop all with `out_ready`=1 → order 1..18, one per cycle.
- Push 40 words while popping continuously → pointers wrap past 15, order is preserved, and there is no stall after the initial fill.
- Random `in_valid`/`out_ready` at 50% for 2000 cycles against a scoreboard → no loss, duplication or reorder; `level` matches the model every cycle.
- Assert `reset` for one cycle with `level`=9 → next cycle `level`=0, `out_valid`=0, `in_ready`=1; the next push/pop returns only post-reset data.
